pc_unit_rv32i: RTL and testbench
================================

// Module: pc_unit_rv32i
// PURPOSE
//  Registered program counter for the RV32I single-cycle/pipelined core; generalises the PC+4 adder.
//  Holds the current PC and selects the next PC: trap vector, jump, taken branch, hold or PC+INC.
//  Adds a run/halt state machine and target-misalignment detection.
//  Feeds instruction-memory address and the PC+INC link value for JAL/JALR write-back.
// PARAMETERS
//  XLEN          32            datapath width of PC and all targets
//  INC           4             sequential increment (4 = RV32I; 2 = compressed-ready build)
//  RESET_VECTOR  32'h00000000  PC value loaded on reset
//  ALIGN_MASK    2'b11         target bits that must be zero (2'b01 when INC=2)
// PORTS
//  clock          in   1     rising-edge clock
//  reset_n        in   1     synchronous active-low reset
//  stall          in   1     hold PC this cycle (hazard)
//  halt_req       in   1     request transition to HALT
//  resume         in   1     leave HALT
//  branch_taken   in   1     load branch_target
//  branch_target  in   XLEN  branch destination
//  jump_en        in   1     load jump_target (JAL/JALR)
//  jump_target    in   XLEN  jump destination (JALR bit0 already cleared upstream)
//  trap_en        in   1     load trap_vector
//  trap_vector    in   XLEN  trap handler address
//  PC             out  XLEN  current PC (registered)
//  PC_4_inc       out  XLEN  PC + INC, combinational from PC, modulo 2^XLEN
//  pc_valid       out  1     PC holds a fetchable address this cycle
//  halted         out  1     FSM in HALT
//  misalign_err   out  1     one-cycle pulse: selected target misaligned
//  misalign_addr  out  XLEN  offending target, held until next error
// BEHAVIOUR
//  Reset (reset_n=0 at edge): PC=RESET_VECTOR, state=BOOT, pc_valid=0, halted=0,
//   misalign_err=0, misalign_addr=0. Reset overrides every other input, any state.
//  FSM states: BOOT, RUN, HALT.
//   BOOT -> RUN unconditionally next edge; PC stays RESET_VECTOR; pc_valid=0 in BOOT.
//   RUN: pc_valid=1. halt_req=1 -> HALT after this cycle's PC update (update still happens).
//   HALT: PC frozen, pc_valid=0, halted=1; all redirects ignored except trap_en.
//     trap_en in HALT: PC<=trap_vector, state->RUN. resume=1 -> RUN, PC unchanged.
//     resume and halt_req both 1 in HALT -> stay HALT.
//  Next-PC priority in RUN (one source per edge):
//   1 trap_en -> trap_vector   2 jump_en -> jump_target   3 branch_taken -> branch_target
//   4 stall -> hold PC         5 else -> PC_4_inc
//   Redirects (1-3) override stall; stall only suppresses sequential increment.
//  Latency: redirect/increment visible on PC one edge after inputs sampled; PC_4_inc
//   follows PC in the same cycle (zero latency).
//  Alignment: if selected target has (target & ALIGN_MASK)!=0 (sources 1-3):
//   PC holds, misalign_err=1 next cycle for exactly one cycle, misalign_addr<=target.
//   trap_vector checked too; misaligned trap also holds PC.
//  Arithmetic: PC_4_inc = PC + INC truncated to XLEN; 32'hFFFFFFFC + 4 = 32'h00000000,
//   no carry/flag. PC never incremented while stalled or halted.
//  RESET_VECTOR itself is not checked for alignment.
// TESTING
//  Reset: reset_n=0 2 cycles then 1 -> PC=0, pc_valid=0 one cycle (BOOT), then PC 0->4->8.
//  Wrap: force via jump_target=32'hFFFFFFFC -> next PC=0xFFFFFFFC, PC_4_inc=0, following PC=0.
//  Priority: PC=0x100, trap_en+jump_en+branch_taken+stall all 1, trap_vector=0x80 -> PC=0x80;
//   then stall+branch_taken(0x200) -> PC=0x200; then stall alone 3 cycles -> PC stays 0x200.
//  Misalign: PC=0x40, branch_taken target=0x1002 -> PC stays 0x40, misalign_err pulse 1 cycle,
//   misalign_addr=0x1002; next cycle PC=0x44.
//  Halt: PC=0x10, halt_req -> PC=0x14 then frozen, halted=1, pc_valid=0; branch ignored;
//   resume -> PC 0x14->0x18; in HALT trap_en(0x80) -> RUN, PC=0x80.
//  Reset mid-run: PC=0x1234567C with stall=1, reset_n=0 one edge -> PC=RESET_VECTOR, BOOT.

Source files
------------

// File: rtl/pc_unit_rv32i_if.sv
// Control and PC bus between the core's next-PC logic and the program counter unit.
interface pc_unit_rv32i_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            halt_req;
  logic            resume;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump_en;
  logic [XLEN-1:0] jump_target;
  logic            trap_en;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PC_4_inc;
  logic            pc_valid;
  logic            halted;
  logic            misalign_err;
  logic [XLEN-1:0] misalign_addr;

  // Core side: drives redirects and control, observes the PC.
  modport master (
    output stall, halt_req, resume,
    output branch_taken, branch_target,
    output jump_en, jump_target,
    output trap_en, trap_vector,
    input  PC, PC_4_inc, pc_valid, halted, misalign_err, misalign_addr
  );

  // PC unit side.
  modport slave (
    input  stall, halt_req, resume,
    input  branch_taken, branch_target,
    input  jump_en, jump_target,
    input  trap_en, trap_vector,
    output PC, PC_4_inc, pc_valid, halted, misalign_err, misalign_addr
  );
endinterface

// File: rtl/pc_unit_rv32i.sv
// RV32I program counter: next-PC selection, run/halt control and target alignment check.
module pc_unit_rv32i #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [1:0]      ALIGN_MASK   = 2'b11
) (
  input logic              clock,
  input logic              reset_n,
  pc_unit_rv32i_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            halted_q;
  logic            misalign_err_q;
  logic [XLEN-1:0] misalign_addr_q;

  logic [XLEN-1:0] pc_inc;
  logic            redir;
  logic [XLEN-1:0] redir_tgt;
  logic            redir_mis;
  logic            trap_mis;

  // Sequential successor, wraps modulo 2^XLEN.
  assign pc_inc = pc_q + XLEN'(INC);

  // Highest-priority redirect source and its alignment status.
  always_comb begin
    redir     = 1'b0;
    redir_tgt = pc_q;
    if (bus.trap_en) begin
      redir     = 1'b1;
      redir_tgt = bus.trap_vector;
    end else if (bus.jump_en) begin
      redir     = 1'b1;
      redir_tgt = bus.jump_target;
    end else if (bus.branch_taken) begin
      redir     = 1'b1;
      redir_tgt = bus.branch_target;
    end
    redir_mis = redir && ((redir_tgt[1:0] & ALIGN_MASK) != 2'b00);
    trap_mis  = (bus.trap_vector[1:0] & ALIGN_MASK) != 2'b00;
  end

  // Run/halt state machine with the PC and status outputs registered alongside.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= ST_BOOT;
      pc_q            <= RESET_VECTOR;
      pc_valid_q      <= 1'b0;
      halted_q        <= 1'b0;
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_err_q <= 1'b0;
      case (state)
        ST_BOOT: begin
          state      <= ST_RUN;
          pc_valid_q <= 1'b1;
          halted_q   <= 1'b0;
        end
        ST_RUN: begin
          // A misaligned redirect holds the PC and records the bad target.
          if (redir) begin
            if (redir_mis) begin
              misalign_err_q  <= 1'b1;
              misalign_addr_q <= redir_tgt;
            end else begin
              pc_q <= redir_tgt;
            end
          end else if (!bus.stall) begin
            pc_q <= pc_inc;
          end
          if (bus.halt_req) begin
            state      <= ST_HALT;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b1;
          end else begin
            pc_valid_q <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        ST_HALT: begin
          // Only a trap can redirect while halted; a misaligned trap leaves the core halted.
          if (bus.trap_en) begin
            if (trap_mis) begin
              misalign_err_q  <= 1'b1;
              misalign_addr_q <= bus.trap_vector;
            end else begin
              pc_q       <= bus.trap_vector;
              state      <= ST_RUN;
              pc_valid_q <= 1'b1;
              halted_q   <= 1'b0;
            end
          end else if (bus.resume && !bus.halt_req) begin
            state      <= ST_RUN;
            pc_valid_q <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        default: begin
          state      <= ST_BOOT;
          pc_valid_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC            = pc_q;
  assign bus.PC_4_inc      = pc_inc;
  assign bus.pc_valid      = pc_valid_q;
  assign bus.halted        = halted_q;
  assign bus.misalign_err  = misalign_err_q;
  assign bus.misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_pc_unit_rv32i.sv
// Directed bench for pc_unit_rv32i with a queued expectation per clock edge.
module tb_pc_unit_rv32i;

  logic clock;
  logic reset_n;

  pc_unit_rv32i_if #(.XLEN(32)) bus ();

  pc_unit_rv32i #(
    .XLEN(32),
    .INC(4),
    .RESET_VECTOR(32'h0000_0000),
    .ALIGN_MASK(2'b11)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic        merr;
    logic [31:0] maddr;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    fails  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, expv);
    end
  endtask

  // Monitor: one expectation is retired after every rising edge while work is queued.
  always @(posedge clock) begin
    exp_t  e;
    string nm;
    #1;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "PC",            bus.PC,            e.pc);
      chk(nm, "PC_4_inc",      bus.PC_4_inc,      e.pc + 32'd4);
      chk(nm, "pc_valid",      32'(bus.pc_valid), 32'(e.valid));
      chk(nm, "halted",        32'(bus.halted),   32'(e.halted));
      chk(nm, "misalign_err",  32'(bus.misalign_err), 32'(e.merr));
      chk(nm, "misalign_addr", bus.misalign_addr, e.maddr);
    end
  end

  task automatic clear_in();
    reset_n           = 1'b1;
    bus.stall         = 1'b0;
    bus.halt_req      = 1'b0;
    bus.resume        = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump_en       = 1'b0;
    bus.jump_target   = 32'h0;
    bus.trap_en       = 1'b0;
    bus.trap_vector   = 32'h0;
  endtask

  // Queue the state expected after the coming edge, let the edge happen, then idle the inputs.
  task automatic cyc(input string nm, input logic [31:0] pc, input logic v, input logic h,
                     input logic e, input logic [31:0] a);
    exp_t x;
    x.pc = pc; x.valid = v; x.halted = h; x.merr = e; x.maddr = a;
    exp_q.push_back(x);
    name_q.push_back(nm);
    @(negedge clock);
    clear_in();
  endtask

  initial begin
    clear_in();
    reset_n = 1'b0;
    @(negedge clock);

    // Reset for two edges, BOOT, then sequential fetch.
    reset_n = 1'b0; cyc("rst1", 32'h0, 0, 0, 0, 32'h0);
    reset_n = 1'b0; cyc("rst2", 32'h0, 0, 0, 0, 32'h0);
    cyc("boot_exit", 32'h0, 1, 0, 0, 32'h0);
    cyc("seq4", 32'h4, 1, 0, 0, 32'h0);
    cyc("seq8", 32'h8, 1, 0, 0, 32'h0);

    // Wrap-around through the top of the address space.
    bus.jump_en = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
    cyc("wrap_jump", 32'hFFFF_FFFC, 1, 0, 0, 32'h0);
    cyc("wrap_zero", 32'h0, 1, 0, 0, 32'h0);

    // Redirect priority and stall interaction.
    bus.jump_en = 1'b1; bus.jump_target = 32'h100;
    cyc("prio_setup", 32'h100, 1, 0, 0, 32'h0);
    bus.trap_en = 1'b1; bus.trap_vector = 32'h80;
    bus.jump_en = 1'b1; bus.jump_target = 32'h300;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h400;
    bus.stall = 1'b1;
    cyc("prio_trap", 32'h80, 1, 0, 0, 32'h0);
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h200;
    cyc("prio_branch_over_stall", 32'h200, 1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1'b1;
      cyc("stall_hold", 32'h200, 1, 0, 0, 32'h0);
    end

    // Misaligned branch and misaligned trap.
    bus.jump_en = 1'b1; bus.jump_target = 32'h40;
    cyc("mis_setup", 32'h40, 1, 0, 0, 32'h0);
    bus.branch_taken = 1'b1; bus.branch_target = 32'h1002;
    cyc("mis_branch", 32'h40, 1, 0, 1, 32'h1002);
    cyc("mis_after", 32'h44, 1, 0, 0, 32'h1002);
    cyc("mis_after2", 32'h48, 1, 0, 0, 32'h1002);
    bus.trap_en = 1'b1; bus.trap_vector = 32'h82;
    cyc("mis_trap", 32'h48, 1, 0, 1, 32'h82);
    cyc("mis_trap_after", 32'h4C, 1, 0, 0, 32'h82);

    // Halt, ignored redirect, resume, trap out of halt.
    bus.jump_en = 1'b1; bus.jump_target = 32'h10;
    cyc("halt_setup", 32'h10, 1, 0, 0, 32'h82);
    bus.halt_req = 1'b1;
    cyc("halt_enter", 32'h14, 0, 1, 0, 32'h82);
    bus.branch_taken = 1'b1; bus.branch_target = 32'h200;
    bus.jump_en = 1'b1; bus.jump_target = 32'h300;
    cyc("halt_ignore", 32'h14, 0, 1, 0, 32'h82);
    bus.resume = 1'b1; bus.halt_req = 1'b1;
    cyc("halt_both", 32'h14, 0, 1, 0, 32'h82);
    bus.resume = 1'b1;
    cyc("resume", 32'h14, 1, 0, 0, 32'h82);
    cyc("resume_inc", 32'h18, 1, 0, 0, 32'h82);
    bus.halt_req = 1'b1;
    cyc("halt_again", 32'h1C, 0, 1, 0, 32'h82);
    bus.trap_en = 1'b1; bus.trap_vector = 32'h80;
    cyc("halt_trap", 32'h80, 1, 0, 0, 32'h82);
    cyc("trap_inc", 32'h84, 1, 0, 0, 32'h82);

    // Reset while stalled mid-run.
    bus.jump_en = 1'b1; bus.jump_target = 32'h1234_567C;
    cyc("rst_mid_setup", 32'h1234_567C, 1, 0, 0, 32'h82);
    bus.stall = 1'b1; reset_n = 1'b0;
    cyc("rst_mid", 32'h0, 0, 0, 0, 32'h0);
    cyc("rst_mid_boot", 32'h0, 1, 0, 0, 32'h0);
    cyc("rst_mid_inc", 32'h4, 1, 0, 0, 32'h0);

    // Drain any outstanding expectations within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
